// File: rtl/cpu_run_pkg.sv
// Shared state encoding and default widths for the lab CPU run controller.
package cpu_run_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_STA_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } run_state_t;

   function automatic int cnt_width(input int max_cycles);
      return $clog2(max_cycles + 1);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Bundle between the run controller and board/CPU: start, expectations, CPU observation, status and trace read.
interface cpu_run_ctrl_if
   import cpu_run_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int STA_W  = CPU_STA_W,
   parameter int CNT_W  = cnt_width(50),
   parameter int TIDX_W = 3
) ();

   logic              start;
   logic [DATA_W-1:0] exp_value;
   logic [DATA_W-1:0] exp_mask;
   logic [STA_W-1:0]  exp_sta;
   logic [STA_W-1:0]  sta_mask;
   logic [DATA_W-1:0] datapath_out;
   logic [STA_W-1:0]  sta;
   logic              cpu_reset;
   logic              busy;
   logic              pass;
   logic              fail;
   logic [CNT_W-1:0]  cycle_count;
   logic [DATA_W-1:0] result;
   logic [TIDX_W-1:0] trace_rd_idx;
   logic [DATA_W-1:0] trace_rd_data;
   logic [TIDX_W:0]   trace_count;

   modport slave (
      input  start, exp_value, exp_mask, exp_sta, sta_mask, datapath_out, sta, trace_rd_idx,
      output cpu_reset, busy, pass, fail, cycle_count, result, trace_rd_data, trace_count
   );

   modport master (
      output start, exp_value, exp_mask, exp_sta, sta_mask, datapath_out, sta, trace_rd_idx,
      input  cpu_reset, busy, pass, fail, cycle_count, result, trace_rd_data, trace_count
   );

endinterface

// File: rtl/run_trace_buf.sv
// Ring buffer of the last DEPTH values; index 0 reads the oldest entry, reads past count return 0.
module run_trace_buf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  wr_ptr;
   logic [IDX_W-1:0]  oldest;
   logic [IDX_W-1:0]  rd_addr;
   logic              full;

   assign full    = count == CNT_W'(DEPTH);
   // Once full, the write pointer sits on the oldest entry; DEPTH is a power of two so the add wraps.
   assign oldest  = full ? wr_ptr : '0;
   assign rd_addr = oldest + rd_idx;
   assign rd_data = ({1'b0, rd_idx} < count) ? mem[rd_addr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + IDX_W'(1);
         if (!full) begin
            count <= count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Holds the CPU in reset, runs it for a bounded budget and checks masked datapath/status for PASS/FAIL.
// Optional change-trace of datapath_out is built only when CPU_RUN_CTRL_TRACE_EN is defined.
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int DATA_W      = CPU_DATA_W,
   parameter int STA_W       = CPU_STA_W,
   parameter int RST_CYCLES  = 2,
   parameter int MAX_CYCLES  = 50,
   parameter int TRACE_DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   cpu_run_ctrl_if.slave bus
);

   localparam int CNT_W  = cnt_width(MAX_CYCLES);
   localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   run_state_t        state;
   run_state_t        state_nxt;
   logic [RCNT_W-1:0] rst_cnt;
   logic [CNT_W-1:0]  cycle_count;
   logic [DATA_W-1:0] result;
   logic              cpu_reset;
   logic              busy;
   logic              pass;
   logic              fail;
   logic              enter_reset;
   logic              rst_done;
   logic              last_cycle;
   logic              data_ok;
   logic              sta_ok;
   logic              match;

   assign data_ok    = ((bus.datapath_out ^ bus.exp_value) & bus.exp_mask) == '0;
   assign sta_ok     = ((bus.sta ^ bus.exp_sta) & bus.sta_mask) == '0;
   assign match      = data_ok && sta_ok;
   assign rst_done   = rst_cnt == RCNT_W'(RST_CYCLES - 1);
   assign last_cycle = cycle_count == CNT_W'(MAX_CYCLES - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      enter_reset = 1'b0;
      case (state)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (bus.start) begin
               state_nxt   = ST_RESET;
               enter_reset = 1'b1;
            end
         end
         ST_RESET: begin
            if (rst_done) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // A match on the final budget cycle still counts as a pass.
            if (match) begin
               state_nxt = ST_PASS;
            end else if (last_cycle) begin
               state_nxt = ST_FAIL;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs are flops decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_reset   <= 1'b1;
         busy        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         rst_cnt     <= '0;
         cycle_count <= '0;
         result      <= '0;
      end else begin
         cpu_reset <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
         busy      <= (state_nxt == ST_RESET) || (state_nxt == ST_RUN);
         pass      <= state_nxt == ST_PASS;
         fail      <= state_nxt == ST_FAIL;
         if (enter_reset) begin
            rst_cnt     <= '0;
            cycle_count <= '0;
            result      <= '0;
         end else if (state == ST_RESET) begin
            rst_cnt <= rst_cnt + RCNT_W'(1);
         end else if (state == ST_RUN) begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (state_nxt != ST_RUN) begin
               result <= bus.datapath_out;
            end
         end
      end
   end

   assign bus.cpu_reset   = cpu_reset;
   assign bus.busy        = busy;
   assign bus.pass        = pass;
   assign bus.fail        = fail;
   assign bus.cycle_count = cycle_count;
   assign bus.result      = result;

`ifdef CPU_RUN_CTRL_TRACE_EN
   logic [DATA_W-1:0] trace_prev;
   logic              trace_first;
   logic              trace_wr;

   assign trace_wr = (state == ST_RUN) && (trace_first || (bus.datapath_out != trace_prev));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trace_prev  <= '0;
         trace_first <= 1'b1;
      end else if (enter_reset) begin
         trace_first <= 1'b1;
      end else if (state == ST_RUN) begin
         trace_first <= 1'b0;
         trace_prev  <= bus.datapath_out;
      end
   end

   run_trace_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (TRACE_DEPTH)
   ) u_trace (
      .clk     (clk),
      .reset   (reset),
      .clr     (enter_reset),
      .wr_en   (trace_wr),
      .wr_data (bus.datapath_out),
      .rd_idx  (bus.trace_rd_idx),
      .rd_data (bus.trace_rd_data),
      .count   (bus.trace_count)
   );
`else
   localparam int TIDX_W = $clog2(TRACE_DEPTH);

   logic unused_trace_idx;

   assign unused_trace_idx  = ^bus.trace_rd_idx;
   assign bus.trace_rd_data = '0;
   assign bus.trace_count   = {(TIDX_W + 1){1'b0}};
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with a CPU stub; trace expectations follow CPU_RUN_CTRL_TRACE_EN.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
   import cpu_run_pkg::*;

   localparam int DATA_W      = CPU_DATA_W;
   localparam int STA_W       = CPU_STA_W;
   localparam int RST_CYCLES  = 2;
   localparam int MAX_CYCLES  = 50;
   localparam int TRACE_DEPTH = 8;
   localparam int CNT_W       = $clog2(MAX_CYCLES + 1);
   localparam int TIDX_W      = $clog2(TRACE_DEPTH);

   logic clk     = 1'b0;
   logic reset   = 1'b1;
   int   mode    = 0;
   int   cpu_cyc = 0;
   int   idx_ctr = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   cpu_run_ctrl_if #(.DATA_W(DATA_W), .STA_W(STA_W), .CNT_W(CNT_W), .TIDX_W(TIDX_W)) bus ();

   cpu_run_ctrl #(
      .DATA_W(DATA_W), .STA_W(STA_W), .RST_CYCLES(RST_CYCLES),
      .MAX_CYCLES(MAX_CYCLES), .TRACE_DEPTH(TRACE_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // CPU program: value on datapath_out after c cycles out of reset, per test mode.
   function automatic logic [DATA_W-1:0] prog_val(input int m, input int c);
      case (m)
         0, 1:    return DATA_W'(c + 5);
         2:       return (c == MAX_CYCLES - 1) ? 16'h1234 : DATA_W'(c);
         3:       return DATA_W'(c * 7 + 1);
         4:       return 16'hFFFF;
         5:       return (c < 20) ? DATA_W'((c / 2 + 1) * 3) : 16'd30;
         default: return '0;
      endcase
   endfunction

   function automatic logic [STA_W-1:0] sta_val(input int m, input int c);
      if (m == 4) return (c >= 3) ? 3'b110 : 3'b100;
      return 3'b000;
   endfunction

   function automatic bit spec_match(input int m, input int c);
      return (((prog_val(m, c) ^ bus.exp_value) & bus.exp_mask) == '0) &&
             (((sta_val(m, c) ^ bus.exp_sta) & bus.sta_mask) == '0);
   endfunction

   always @(posedge clk) begin
      if (bus.cpu_reset) cpu_cyc <= 0;
      else               cpu_cyc <= cpu_cyc + 1;
   end
   assign bus.datapath_out = prog_val(mode, cpu_cyc);
   assign bus.sta          = sta_val(mode, cpu_cyc);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a run is fully described by its start edge, the first matching RUN sample K and its value.
   int m_active = 0;
   int m_t      = 0;
   int m_K      = 0;
   int m_mode   = 0;
   bit m_pass   = 1'b0;
   logic [DATA_W-1:0] m_res = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active = 0;
      end else if (m_active != 0 && m_t < RST_CYCLES + m_K) begin
         m_t = m_t + 1;
      end else if (bus.start) begin
         m_active = 1;
         m_t      = 0;
         m_mode   = mode;
         m_pass   = 1'b0;
         m_K      = MAX_CYCLES;
         for (int k = MAX_CYCLES; k >= 1; k--) begin
            if (spec_match(mode, k - 1)) begin
               m_K    = k;
               m_pass = 1'b1;
            end
         end
         m_res = prog_val(mode, m_K - 1);
      end
   end

   always @(negedge clk) begin
      int e_cr, e_busy, e_pass, e_fail, e_cnt, e_res, n, j, e_tcnt, e_tdat, ridx;
      logic [DATA_W-1:0] v;
      logic [DATA_W-1:0] tq[$];
      e_cr = 1; e_busy = 0; e_pass = 0; e_fail = 0; e_cnt = 0; e_res = 0; n = 0;
      if (m_active != 0) begin
         if (m_t < RST_CYCLES) begin
            e_busy = 1;
         end else begin
            j    = m_t - RST_CYCLES;
            e_cr = 0;
            if (j < m_K) begin
               e_busy = 1; e_cnt = j; n = j;
            end else begin
               e_pass = m_pass ? 1 : 0; e_fail = m_pass ? 0 : 1;
               e_cnt  = m_K; e_res = 32'(m_res); n = m_K;
            end
         end
      end
      tq.delete();
      for (int k = 1; k <= n; k++) begin
         v = prog_val(m_mode, k - 1);
         if (tq.size() == 0 || tq[$] != v) tq.push_back(v);
      end
      while (tq.size() > TRACE_DEPTH) void'(tq.pop_front());
`ifdef CPU_RUN_CTRL_TRACE_EN
      e_tcnt = tq.size();
      ridx   = int'(bus.trace_rd_idx);
      e_tdat = (ridx < e_tcnt) ? 32'(tq[ridx]) : 0;
`else
      e_tcnt = 0;
      e_tdat = 0;
`endif
      chk("cyc_cpu_reset",   32'(bus.cpu_reset),     e_cr);
      chk("cyc_busy",        32'(bus.busy),          e_busy);
      chk("cyc_pass",        32'(bus.pass),          e_pass);
      chk("cyc_fail",        32'(bus.fail),          e_fail);
      chk("cyc_cycle_count", 32'(bus.cycle_count),   e_cnt);
      chk("cyc_result",      32'(bus.result),        e_res);
      chk("cyc_trace_count", 32'(bus.trace_count),   e_tcnt);
      chk("cyc_trace_data",  32'(bus.trace_rd_data), e_tdat);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      idx_ctr++;
      bus.trace_rd_idx = TIDX_W'(idx_ctr);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic setup(input int m, input logic [15:0] ev, input logic [15:0] em,
                        input logic [2:0] es, input logic [2:0] sm);
      mode          = m;
      bus.exp_value = ev;
      bus.exp_mask  = em;
      bus.exp_sta   = es;
      bus.sta_mask  = sm;
   endtask

   task automatic wait_done(input string name, input int budget);
      int c = 0;
      while (!(bus.pass || bus.fail) && c < budget) begin
         tick();
         c++;
      end
      chk({name, "_done"}, 32'(bus.pass || bus.fail), 1);
   endtask

   task automatic chk_end(input string name, input int p, input int cnt, input int res);
      chk({name, "_pass"},   32'(bus.pass),        p);
      chk({name, "_fail"},   32'(bus.fail),        1 - p);
      chk({name, "_count"},  32'(bus.cycle_count), cnt);
      chk({name, "_result"}, 32'(bus.result),      res);
   endtask

   task automatic chk_trace(input string name, input int idx, input int exp);
      bus.trace_rd_idx = TIDX_W'(idx);
      #1;
      chk(name, 32'(bus.trace_rd_data), exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      bus.start = 1'b0;
      bus.trace_rd_idx = '0;
      setup(0, 16'h0, 16'h0, 3'b0, 3'b0);
      #1 reset = 1'b0;
      repeat (3) tick();
      chk("rst_cpu_reset", 32'(bus.cpu_reset), 1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_count", 32'(bus.cycle_count), 0);
      chk("rst_trace_count", 32'(bus.trace_count), 0);
      reset = 1'b1;
      tick();

      // Nominal: CPU reaches 16 on its 12th RUN cycle.
      setup(0, 16'd16, 16'hFFFF, 3'b000, 3'b000);
      pulse_start();
      rc = 0;
      while (bus.cpu_reset && rc < 10) begin
         rc++;
         tick();
      end
      chk("nom_cpu_reset_cycles", rc, RST_CYCLES);
      wait_done("nom", 200);
      chk_end("nom", 1, 12, 16);
`ifdef CPU_RUN_CTRL_TRACE_EN
      chk("nom_trace_count", 32'(bus.trace_count), 8);
      chk_trace("nom_trace_idx0", 0, 9);
      chk_trace("nom_trace_idx7", 7, 16);
`endif
      tick();

      // Timeout, started from PASS; a start pulse during RUN is ignored.
      setup(1, 16'hDEAD, 16'hFFFF, 3'b000, 3'b000);
      pulse_start();
      chk("rerun_busy", 32'(bus.busy), 1);
      chk("rerun_cpu_reset", 32'(bus.cpu_reset), 1);
      chk("rerun_pass", 32'(bus.pass), 0);
      repeat (5) tick();
      pulse_start();
      wait_done("tmo", 200);
      chk_end("tmo", 0, 50, 54);
      tick();

      // Match on the last budget cycle wins over timeout.
      setup(2, 16'h1234, 16'hFFFF, 3'b000, 3'b000);
      pulse_start();
      wait_done("bnd", 200);
      chk_end("bnd", 1, 50, 16'h1234);
      tick();

      setup(3, 16'hBEEF, 16'h0000, 3'b111, 3'b000);
      pulse_start();
      wait_done("zero", 200);
      chk_end("zero", 1, 1, 1);
      tick();

      // Status only: Z (bit 1) appears on the 4th RUN cycle, bit 2 is masked off.
      setup(4, 16'h0000, 16'h0000, 3'b010, 3'b010);
      pulse_start();
      wait_done("sta", 200);
      chk_end("sta", 1, 4, 16'hFFFF);
      tick();

      // Ten distinct values, each held two cycles, then constant.
      setup(5, 16'hDEAD, 16'hFFFF, 3'b000, 3'b000);
      pulse_start();
      wait_done("trc", 200);
      chk_end("trc", 0, 50, 30);
`ifdef CPU_RUN_CTRL_TRACE_EN
      chk("trc_trace_count", 32'(bus.trace_count), 8);
      chk_trace("trc_idx0", 0, 9);
      chk_trace("trc_idx7", 7, 30);
`else
      for (int i = 0; i < TRACE_DEPTH; i++) begin
         chk_trace("trc_off_data", i, 0);
         tick();
      end
`endif
      tick();

      // Asynchronous reset in the middle of a run.
      setup(1, 16'hDEAD, 16'hFFFF, 3'b000, 3'b000);
      pulse_start();
      repeat (10) tick();
      chk("arst_pre_busy", 32'(bus.busy), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_cpu_reset", 32'(bus.cpu_reset), 1);
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_pass", 32'(bus.pass), 0);
      chk("arst_fail", 32'(bus.fail), 0);
      chk("arst_count", 32'(bus.cycle_count), 0);
      chk("arst_trace_count", 32'(bus.trace_count), 0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      setup(0, 16'd16, 16'hFFFF, 3'b000, 3'b000);
      pulse_start();
      wait_done("post", 200);
      chk_end("post", 1, 12, 16);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
